// File: rtl/imm_offs_stage.sv
// Immediate/branch-offset decode for an instruction bundle, followed by a
// small circular FIFO of decoded bundles and a saturating illegal-lane counter.
module imm_offs_stage #(
  parameter int LANES       = 2,
  parameter int DEPTH       = 2,
  parameter int LU12I_SHIFT = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES-1:0]      in_lane_vld,
  input  logic [32*LANES-1:0]   in_inst,
  input  logic [32*LANES-1:0]   in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES-1:0]      out_lane_vld,
  output logic [32*LANES-1:0]   out_imm,
  output logic [32*LANES-1:0]   out_offs,
  output logic [32*LANES-1:0]   out_target,
  output logic [LANES-1:0]      out_illegal,
  output logic [15:0]           illegal_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int LW    = 32 * LANES;
  localparam int EW    = 2 * LANES + 3 * LW;

  function automatic logic is_illegal(input logic [31:0] inst);
    return inst[31] | ~(inst[30] | inst[29] | inst[28] | inst[25] | inst[22]);
  endfunction

  function automatic logic signed [31:0] dec_imm(input logic [31:0] inst);
    logic signed [31:0] imm;
    imm = '0;
    if (inst[31]) begin
      imm = '0;
    end else if (inst[30]) begin
      imm = 32'sd4;
    end else if (inst[29]) begin
      imm = {{20{inst[21]}}, inst[21:10]};
    end else if (inst[28]) begin
      if (LU12I_SHIFT != 0) imm = {inst[24:5], 12'h000};
      else                  imm = {{12{inst[24]}}, inst[24:5]};
    end else if (inst[25]) begin
      if (inst[24]) imm = {{20{inst[21]}}, inst[21:10]};
      else          imm = {20'h00000, inst[21:10]};
    end else if (inst[22]) begin
      imm = {27'h0000000, inst[14:10]};
    end
    return imm;
  endfunction

  // Long-form branches (b/bl) carry a 26-bit word offset split across two fields.
  function automatic logic signed [31:0] dec_offs(input logic [31:0] inst);
    logic signed [31:0] offs;
    if (inst[31:27] == 5'b01010) offs = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
    else                         offs = {{14{inst[25]}}, inst[25:10], 2'b00};
    return offs;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [2:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {14'h0000, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Stage p0: per-lane decode of the incoming bundle
  logic [LW-1:0]    imm_p0;
  logic [LW-1:0]    offs_p0;
  logic [LW-1:0]    tgt_p0;
  logic [LANES-1:0] ill_p0;
  logic [2:0]       ill_pop_p0;

  always_comb begin
    imm_p0     = '0;
    offs_p0    = '0;
    tgt_p0     = '0;
    ill_p0     = '0;
    ill_pop_p0 = '0;
    for (int l = 0; l < LANES; l++) begin
      logic [31:0]        inst;
      logic signed [31:0] pc;
      logic signed [31:0] offs;
      inst                 = in_inst[32*l +: 32];
      pc                   = $signed(in_pc[32*l +: 32]);
      offs                 = dec_offs(inst);
      imm_p0[32*l +: 32]   = dec_imm(inst);
      offs_p0[32*l +: 32]  = offs;
      tgt_p0[32*l +: 32]   = pc + offs;
      ill_p0[l]            = in_lane_vld[l] & is_illegal(inst);
      ill_pop_p0           = ill_pop_p0 + {2'b00, ill_p0[l]};
    end
  end

  // Stage p1: bundle FIFO
  logic [EW-1:0]    mem_q [DEPTH];
  logic [EW-1:0]    wr_entry_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      illegal_cnt_q, illegal_cnt_d;
  logic             push, pop;

  assign in_ready    = (count_q < CNT_W'(DEPTH));
  assign out_valid   = (count_q != '0);
  assign push        = in_valid & in_ready & ~flush;
  assign pop         = out_valid & out_ready & ~flush;
  assign wr_entry_d  = {in_lane_vld, ill_p0, imm_p0, offs_p0, tgt_p0};
  assign illegal_cnt = illegal_cnt_q;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    illegal_cnt_d = illegal_cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d      = ptr_inc(wr_ptr_q);
        illegal_cnt_d = sat_add16(illegal_cnt_q, ill_pop_p0);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      illegal_cnt_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && push) mem_q[wr_ptr_q] <= wr_entry_d;
  end

  // Storage is not reset, so the head is masked to zero whenever the FIFO is empty.
  logic [EW-1:0] head;
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    out_lane_vld = '0;
    out_illegal  = '0;
    out_imm      = '0;
    out_offs     = '0;
    out_target   = '0;
    if (out_valid) begin
      out_lane_vld = head[EW-1 -: LANES];
      out_illegal  = head[3*LW +: LANES];
      out_imm      = head[2*LW +: LW];
      out_offs     = head[LW +: LW];
      out_target   = head[0 +: LW];
    end
  end

endmodule
